ysyx_25020037_ifu: RTL and testbench

Instruction fetch unit; the producer end of the fetch-to-decode interface.
- Owns the architectural fetch PC and issues single-beat instruction reads over an AXI4-Lite read channel.
- Presents {pc, inst} on fu_to_du_bus with an ifu_valid/idu_ready handshake.
- Takes redirects from execute (exu_dnpc_valid/exu_dnpc) and discards any stale in-flight fetch.

---
 rtl/ysyx_25020037_ifu.sv | 140 ++++++++++++++
 tb/tb_ysyx_25020037_ifu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one AXI4-Lite read at a time, hands {pc, inst} to decode.
// Optional macro YSYX_25020037_IFU_FAULT_CHECK_EN turns a non-OKAY read response into an ebreak instruction.
module ysyx_25020037_ifu #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h3000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     idu_ready,
  output logic                     ifu_valid,
  output logic [ADDR_W+DATA_W-1:0] fu_to_du_bus,
  input  logic                     exu_dnpc_valid,
  input  logic [ADDR_W-1:0]        exu_dnpc,
  output logic [ADDR_W-1:0]        araddr,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_W-1:0]        rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  output logic                     rready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [DATA_W-1:0] EBREAK = DATA_W'(32'h0010_0073);

  logic [1:0]               state_q, state_d;
  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic [ADDR_W-1:0]        araddr_q, araddr_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic                     ifu_valid_q, ifu_valid_d;
  logic [ADDR_W+DATA_W-1:0] bus_q, bus_d;
  logic                     drop_q, drop_d;

  logic [ADDR_W-1:0] redir_pc;
  logic [DATA_W-1:0] inst_w;
  logic              unused_bits;

  assign redir_pc = {exu_dnpc[ADDR_W-1:2], 2'b00};

`ifdef YSYX_25020037_IFU_FAULT_CHECK_EN
  assign inst_w = (rresp != 2'b00) ? EBREAK : rdata;
`else
  assign inst_w = rdata;
`endif

  assign unused_bits = ^{exu_dnpc[1:0], rresp, EBREAK};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    ifu_valid_d = ifu_valid_q;
    bus_d       = bus_q;
    drop_d      = drop_q;

    // A redirect always wins the PC, whatever the FSM is doing.
    if (exu_dnpc_valid) pc_d = redir_pc;

    unique case (state_q)
      S_IDLE: begin
        state_d   = S_AR;
        arvalid_d = 1'b1;
        araddr_d  = pc_d;
      end
      S_AR: begin
        // The AR beat already on the bus must complete; its data is dropped later.
        if (exu_dnpc_valid) drop_d = 1'b1;
        if (arready) begin
          state_d   = S_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_R: begin
        if (rvalid) begin
          rready_d = 1'b0;
          if (drop_q || exu_dnpc_valid) begin
            drop_d    = 1'b0;
            state_d   = S_AR;
            arvalid_d = 1'b1;
            araddr_d  = pc_d;
          end else begin
            ifu_valid_d = 1'b1;
            bus_d       = {pc_q, inst_w};
            state_d     = S_OUT;
          end
        end else if (exu_dnpc_valid) begin
          drop_d = 1'b1;
        end
      end
      S_OUT: begin
        if (exu_dnpc_valid || idu_ready) begin
          if (!exu_dnpc_valid) pc_d = pc_q + ADDR_W'(4);
          ifu_valid_d = 1'b0;
          state_d     = S_AR;
          arvalid_d   = 1'b1;
          araddr_d    = pc_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      ifu_valid_q <= 1'b0;
      bus_q       <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      ifu_valid_q <= ifu_valid_d;
      bus_q       <= bus_d;
      drop_q      <= drop_d;
    end
  end

  assign araddr       = araddr_q;
  assign arvalid      = arvalid_q;
  assign rready       = rready_q;
  assign ifu_valid    = ifu_valid_q;
  assign fu_to_du_bus = bus_q;

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Randomized bench for ysyx_25020037_ifu: AXI slave plus transaction-level fetch model.
module tb_ysyx_25020037_ifu;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;
`ifdef YSYX_25020037_IFU_FAULT_CHECK_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        idu_ready = 1'b0;
  logic        ifu_valid;
  logic [63:0] fu_to_du_bus;
  logic        exu_dnpc_valid = 1'b0;
  logic [31:0] exu_dnpc = '0;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  ysyx_25020037_ifu dut (
    .clk(clk), .rst(rst), .idu_ready(idu_ready), .ifu_valid(ifu_valid),
    .fu_to_du_bus(fu_to_du_bus), .exu_dnpc_valid(exu_dnpc_valid), .exu_dnpc(exu_dnpc),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata),
    .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // stimulus knobs
  int unsigned ar_pct = 100, rdy_pct = 100, rd_min = 0, rd_max = 0;
  int unsigned redir_pct = 0, fault_pct = 0;
  int          redir_mode = 0;
  logic [31:0] redir_tgt = '0;
  bit          fix_on = 1'b0;
  logic [31:0] fix_val = '0;

  // reference model: architectural pc, the one outstanding request, the presented bundle
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] req_addr = '0;
  bit          req_stale = 1'b0;
  bit          ar_exp = 1'b0, ar_new = 1'b0, rd_exp = 1'b0, v_exp = 1'b0;
  logic [63:0] bus_exp = '0;
  int unsigned rdelay = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return fix_on ? fix_val : ({a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F);
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] d, input logic [1:0] r);
    return (FAULT_EN && r != 2'b00) ? 32'h0010_0073 : d;
  endfunction

  task automatic model_reset();
    exp_pc = RESET_PC; req_stale = 1'b0;
    ar_exp = 1'b1; ar_new = 1'b1; rd_exp = 1'b0; v_exp = 1'b0;
    bus_exp = '0;
  endtask

  task automatic cycle();
    bit cur_ar, cur_rd, cur_v, redir;
    logic [31:0] tgt;
    @(negedge clk);
    chk("arvalid", 64'(arvalid), 64'(ar_exp));
    chk("rready", 64'(rready), 64'(rd_exp));
    chk("ifu_valid", 64'(ifu_valid), 64'(v_exp));
    chk("bus", fu_to_du_bus, bus_exp);
    if (ar_exp) begin
      if (ar_new) begin
        chk("araddr_new", 64'(araddr), 64'(exp_pc));
        req_addr = exp_pc; req_stale = 1'b0; ar_new = 1'b0;
      end else begin
        chk("araddr_hold", 64'(araddr), 64'(req_addr));
      end
    end
    cur_ar = ar_exp; cur_rd = rd_exp; cur_v = v_exp;

    arready = ($urandom_range(99) < ar_pct);
    if (cur_rd && rdelay == 0) begin
      rvalid = 1'b1;
      rdata  = mem(req_addr);
      rresp  = ($urandom_range(99) < fault_pct) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
      rresp  = 2'($urandom);
      if (cur_rd) rdelay--;
    end
    idu_ready = ($urandom_range(99) < rdy_pct);
    case (redir_mode)
      1: redir = cur_rd;
      2: redir = cur_v && idu_ready;
      3: redir = cur_ar && !arready;
      default: redir = ($urandom_range(999) < redir_pct);
    endcase
    tgt = (redir_mode == 0) ? $urandom : redir_tgt;
    if (redir) redir_mode = 0;
    exu_dnpc_valid = redir;
    exu_dnpc       = redir ? tgt : $urandom;

    if (cur_ar && arready) begin
      ar_exp = 1'b0; rd_exp = 1'b1;
      rdelay = $urandom_range(rd_max, rd_min);
    end
    if (cur_ar && redir) req_stale = 1'b1;
    if (cur_rd && rvalid) begin
      rd_exp = 1'b0;
      if (req_stale || redir) begin
        ar_exp = 1'b1; ar_new = 1'b1;
      end else begin
        v_exp = 1'b1;
        bus_exp = {req_addr, exp_inst(rdata, rresp)};
      end
    end else if (cur_rd && redir) begin
      req_stale = 1'b1;
    end
    if (cur_v && (redir || idu_ready)) begin
      v_exp = 1'b0; ar_exp = 1'b1; ar_new = 1'b1;
      if (!redir) exp_pc = exp_pc + 32'd4;
    end
    if (redir) exp_pc = tgt & 32'hFFFF_FFFC;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_valid", 64'(ifu_valid), 64'd0);
    chk("rst_bus", fu_to_du_bus, 64'd0);
    rst = 1'b0;
    model_reset();

    // plain fetch, zero-wait memory
    fix_on = 1'b1; fix_val = 32'h0000_0413;
    run(7);
    fix_on = 1'b0;

    // decode backpressure in OUT
    rdy_pct = 0;
    for (int i = 0; i < 20 && !v_exp; i++) cycle();
    chk("bp_reach_out", 64'(v_exp), 64'd1);
    run(5);
    rdy_pct = 100;
    run(4);

    // redirect while waiting for a slow response
    rd_min = 4; rd_max = 4; redir_tgt = 32'h3000_0100; redir_mode = 1;
    for (int i = 0; i < 30 && redir_mode != 0; i++) cycle();
    chk("rdR_fired", 64'(redir_mode), 64'd0);
    rd_min = 0; rd_max = 0;
    run(12);

    // redirect coinciding with the decode handshake
    redir_tgt = 32'h3000_0203; redir_mode = 2;
    for (int i = 0; i < 30 && redir_mode != 0; i++) cycle();
    chk("rdOUT_fired", 64'(redir_mode), 64'd0);
    run(6);

    // redirect while AR is stalled
    ar_pct = 0; redir_tgt = 32'h3000_0300; redir_mode = 3;
    for (int i = 0; i < 30 && redir_mode != 0; i++) cycle();
    chk("rdAR_fired", 64'(redir_mode), 64'd0);
    run(3);
    ar_pct = 100;
    run(10);

    // pc wraps past the top of the address space
    redir_tgt = 32'hFFFF_FFFA; redir_mode = 2;
    for (int i = 0; i < 30 && redir_mode != 0; i++) cycle();
    chk("wrap_fired", 64'(redir_mode), 64'd0);
    run(10);

    // error response
    fix_on = 1'b1; fix_val = 32'h1234_5678; fault_pct = 100;
    run(8);
    fix_on = 1'b0; fault_pct = 0;

    for (int blk = 0; blk < 30; blk++) begin
      ar_pct    = $urandom_range(100, 30);
      rdy_pct   = $urandom_range(100, 20);
      rd_max    = $urandom_range(3, 0);
      redir_pct = $urandom_range(80, 0);
      fault_pct = $urandom_range(30, 0);
      run(100);
    end

    // asynchronous reset in the middle of a read
    redir_pct = 0; ar_pct = 100; rd_min = 3; rd_max = 3;
    for (int i = 0; i < 30 && !rd_exp; i++) cycle();
    chk("arst_reach_r", 64'(rd_exp), 64'd1);
    @(posedge clk);
    #2;
    chk("arst_pre_rready", 64'(rready), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_rready", 64'(rready), 64'd0);
    chk("arst_arvalid", 64'(arvalid), 64'd0);
    chk("arst_araddr", 64'(araddr), 64'd0);
    chk("arst_valid", 64'(ifu_valid), 64'd0);
    chk("arst_bus", fu_to_du_bus, 64'd0);
    arready = 1'b0; rvalid = 1'b0; idu_ready = 1'b0; exu_dnpc_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rd_min = 0;
    for (int blk = 0; blk < 3; blk++) begin
      ar_pct    = $urandom_range(100, 40);
      rdy_pct   = $urandom_range(100, 30);
      rd_max    = $urandom_range(2, 0);
      redir_pct = $urandom_range(60, 0);
      run(100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
